// File: rtl/mw_add_seq.sv
// mw_add_seq: streaming multi-word adder. Operands arrive one WIDTH-bit word per beat,
// least-significant word first. The carry chains between beats of a packet, and in_last
// marks the packet's final word. There is a one-entry registered output stage with a
// valid/ready handshake, so the block sustains one beat per cycle.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   in_valid, in_ready  input handshake; in_ready = !out_valid || out_ready
//   a, b                operand words
//   cin                 packet carry-in, used only on the first beat of a packet
//   in_last             the beat carries the most-significant word of the packet
//   out_valid/out_ready output handshake
//   s, out_last         sum word and its last-word marker
//   cout                packet carry-out; nonzero only when out_valid && out_last
//   ovf                 present only with MW_ADD_SEQ_OVF_EN: signed overflow of the final word
//
// Configuration macro: MW_ADD_SEQ_OVF_EN adds the ovf output.
module mw_add_seq #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             out_last,
  output logic             cout
`ifdef MW_ADD_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [0:0] {StFirst, StChain} state_e;

  state_e           state_q, state_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             last_q, last_d;
  logic             cout_q, cout_d;

  logic             accept;
  logic             ci;
  logic [WIDTH:0]   sum_full;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign ci       = (state_q == StFirst) ? cin : carry_q;
  assign sum_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFirst;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = in_last ? StFirst : StChain;
    end
  end

  // Datapath next-state logic
  always_comb begin
    carry_d = carry_q;
    valid_d = valid_q;
    s_d     = s_q;
    last_d  = last_q;
    cout_d  = cout_q;
    if (accept) begin
      carry_d = sum_full[WIDTH];
      valid_d = 1'b1;
      s_d     = sum_full[WIDTH-1:0];
      last_d  = in_last;
      // The carry out of a middle word is internal, so only a final word exposes it.
      cout_d  = sum_full[WIDTH] & in_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      s_q     <= '0;
      last_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      valid_q <= valid_d;
      s_q     <= s_d;
      last_q  <= last_d;
      cout_q  <= cout_d;
    end
  end

  assign out_valid = valid_q;
  assign s         = s_q;
  assign out_last  = last_q;
  // After a drain the word is held but no longer valid, so the flags are masked.
  assign cout      = cout_q & valid_q & last_q;

`ifdef MW_ADD_SEQ_OVF_EN
  logic ovf_q, ovf_d;
  logic msb_cin;

  // Carry into the MSB, recovered from the MSB sum bit.
  assign msb_cin = a[WIDTH-1] ^ b[WIDTH-1] ^ sum_full[WIDTH-1];

  always_comb begin
    ovf_d = ovf_q;
    if (accept) begin
      ovf_d = (msb_cin ^ sum_full[WIDTH]) & in_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q & valid_q & last_q;
`endif

endmodule

// File: tb/tb_mw_add_seq.sv
// Bench for mw_add_seq: directed vector table with back-to-back beats, followed by
// hand-written stall and mid-packet-reset sequences.
module tb_mw_add_seq;

  localparam int unsigned W = 64;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         cin, in_last;
  logic         out_valid, out_ready;
  logic [W-1:0] s;
  logic         out_last, cout;
`ifdef MW_ADD_SEQ_OVF_EN
  logic         ovf;
`endif

  mw_add_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s(s),
    .out_last(out_last),
    .cout(cout)
`ifdef MW_ADD_SEQ_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         last;
    logic [W-1:0] es;
    logic         elast;
    logic         ecout;
    logic         eovf;
  } vec_t;

  localparam int N = 9;
  vec_t vecs[N];

  initial begin
    // a, b, cin, last, expected s, out_last, cout, ovf
    vecs[0] = '{64'd123, 64'd123, 1'b1, 1'b1, 64'd247, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{64'd200, 64'd243, 1'b0, 1'b1, 64'd443, 1'b1, 1'b0, 1'b0};
    // Two-beat packet; the cin on the second beat is ignored.
    vecs[2] = '{ONES, 64'd1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{64'd0, 64'd0, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0, 1'b0};
    // Single beat: -1 + -1 + 1 = -1, carry out 1, no signed overflow.
    vecs[4] = '{ONES, ONES, 1'b1, 1'b1, ONES, 1'b1, 1'b1, 1'b0};
    // Three-beat packet.
    vecs[5] = '{ONES, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{64'd5, 64'd6, 1'b1, 1'b0, 64'd12, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{ONES, 64'd1, 1'b0, 1'b1, 64'd0, 1'b1, 1'b1, 1'b0};
    // Signed overflow at the positive limit.
    vecs[8] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 64'h8000_0000_0000_0000,
                1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("reset out_valid", W'(out_valid), 64'd0);
    chk("reset s", s, 64'd0);
    chk("reset out_last", W'(out_last), 64'd0);
    chk("reset cout", W'(cout), 64'd0);
    chk("reset in_ready", W'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Back-to-back vectors at full throughput.
    for (int i = 0; i <= N; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d in_ready", i), W'(in_ready), 64'd1);
      if (i > 0) begin
        chk($sformatf("vec%0d out_valid", i - 1), W'(out_valid), 64'd1);
        chk($sformatf("vec%0d s", i - 1), s, vecs[i-1].es);
        chk($sformatf("vec%0d out_last", i - 1), W'(out_last), W'(vecs[i-1].elast));
        chk($sformatf("vec%0d cout", i - 1), W'(cout), W'(vecs[i-1].ecout));
`ifdef MW_ADD_SEQ_OVF_EN
        chk($sformatf("vec%0d ovf", i - 1), W'(ovf), W'(vecs[i-1].eovf));
`endif
      end
      if (i < N) begin
        in_valid = 1'b1;
        a = vecs[i].a;
        b = vecs[i].b;
        cin = vecs[i].cin;
        in_last = vecs[i].last;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("drain out_valid", W'(out_valid), 64'd0);
    chk("drain cout", W'(cout), 64'd0);

    // Stall: the held word stays stable and in_ready drops while the output is blocked.
    in_valid = 1'b1;
    a = 64'd10;
    b = 64'd20;
    cin = 1'b0;
    in_last = 1'b1;
    @(negedge clk);
    a = 64'd1;
    b = 64'd2;
    out_ready = 1'b0;
    #1;
    repeat (3) begin
      chk("stall out_valid", W'(out_valid), 64'd1);
      chk("stall in_ready", W'(in_ready), 64'd0);
      chk("stall s", s, 64'd30);
      chk("stall out_last", W'(out_last), 64'd1);
      chk("stall cout", W'(cout), 64'd0);
      @(negedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    chk("unstall in_ready", W'(in_ready), 64'd1);
    @(negedge clk);
    chk("after stall out_valid", W'(out_valid), 64'd1);
    chk("after stall s", s, 64'd3);
    in_valid = 1'b0;
    @(negedge clk);
    chk("after stall drain", W'(out_valid), 64'd0);

    // Reset mid-packet discards the carry from the partial packet.
    in_valid = 1'b1;
    a = ONES;
    b = 64'd1;
    cin = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre-reset out_valid", W'(out_valid), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("async reset out_valid", W'(out_valid), 64'd0);
    chk("async reset s", s, 64'd0);
    chk("async reset out_last", W'(out_last), 64'd0);
    chk("async reset in_ready", W'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post-reset in_ready", W'(in_ready), 64'd1);
    in_valid = 1'b1;
    a = 64'd0;
    b = 64'd0;
    cin = 1'b0;
    in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post-reset out_valid", W'(out_valid), 64'd1);
    chk("post-reset s", s, 64'd0);
    chk("post-reset out_last", W'(out_last), 64'd1);
    chk("post-reset cout", W'(cout), 64'd0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
